// File: rtl/trap_monitor_pkg.sv
// Shared types for the trap monitor: exit causes, FSM states and the history entry layout.
// History fields are sized for the widest supported pc/inst; narrower configurations zero-extend.
package trap_monitor_pkg;

    localparam int HIST_PC_W   = 64;
    localparam int HIST_INST_W = 32;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_GOOD = 2'd1,
        CAUSE_BAD  = 2'd2,
        CAUSE_HANG = 2'd3
    } exit_cause_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic [HIST_PC_W-1:0]   pc;
        logic [HIST_INST_W-1:0] inst;
    } hist_entry_t;

endpackage

// File: rtl/trap_hist_ring.sv
// Commit history ring: up to LANES writes per cycle in lane order, saturating fill count,
// combinational oldest-first read port (index 0 = oldest entry still held).
module trap_hist_ring
    import trap_monitor_pkg::*;
#(
    parameter int HIST_DEPTH = 8,
    parameter int XLEN       = 64,
    parameter int ILEN       = 32,
    parameter int LANES      = 1,
    localparam int FILL_W    = $clog2(HIST_DEPTH + 1)
) (
    input  logic                    i_clock,
    input  logic                    i_rst_n,
    input  logic [LANES-1:0]        i_wr_vld,
    input  logic [LANES*XLEN-1:0]   i_wr_pc,
    input  logic [LANES*ILEN-1:0]   i_wr_inst,
    input  logic [FILL_W-1:0]       i_rd_idx,
    output logic [XLEN-1:0]         o_rd_pc,
    output logic [ILEN-1:0]         o_rd_inst,
    output logic [FILL_W-1:0]       o_fill
);

    localparam int PTR_W = $clog2(HIST_DEPTH);
    localparam int CNT_W = $clog2(LANES + 1);
    localparam int SUM_W = FILL_W + 1;

    hist_entry_t        r_mem [HIST_DEPTH];
    logic [PTR_W-1:0]   r_wrptr;
    logic [FILL_W-1:0]  r_fill;
    logic [PTR_W-1:0]   w_slot [LANES];
    logic [CNT_W-1:0]   w_cnt;
    logic [SUM_W-1:0]   w_fill_sum;
    logic [PTR_W-1:0]   w_rd_slot;

    // Each written lane lands after all lower written lanes, so sparse valid masks pack densely.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            w_slot[i] = r_wrptr + PTR_W'(w_cnt);
            w_cnt     = w_cnt + CNT_W'(i_wr_vld[i]);
        end
        w_fill_sum = {1'b0, r_fill} + SUM_W'(w_cnt);
    end

    always_ff @(posedge i_clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (i_wr_vld[i]) begin
                r_mem[w_slot[i]] <= '{pc:   HIST_PC_W'(i_wr_pc[i*XLEN +: XLEN]),
                                      inst: HIST_INST_W'(i_wr_inst[i*ILEN +: ILEN])};
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrptr <= '0;
            r_fill  <= '0;
        end else begin
            r_wrptr <= r_wrptr + PTR_W'(w_cnt);
            r_fill  <= (w_fill_sum >= SUM_W'(HIST_DEPTH)) ? FILL_W'(HIST_DEPTH)
                                                          : w_fill_sum[FILL_W-1:0];
        end
    end

    assign w_rd_slot = r_wrptr - PTR_W'(r_fill) + PTR_W'(i_rd_idx);
    assign o_rd_pc   = r_mem[w_rd_slot].pc[XLEN-1:0];
    assign o_rd_inst = r_mem[w_rd_slot].inst[ILEN-1:0];
    assign o_fill    = r_fill;

endmodule

// File: rtl/trap_monitor.sv
// Commit monitor: counters, history capture, good/bad trap or hang detection, then oldest-first drain.
// Cause/halted 1 cycle, first dump 2 cycles after detection; no backpressure. TRAP_MONITOR_DISPLAY_EN adds sim-only reports.
module trap_monitor
    import trap_monitor_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int ILEN       = 32,
    parameter int LANES      = 1,
    parameter int HIST_DEPTH = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [LANES-1:0]       commit_valid,
    input  logic [LANES*XLEN-1:0]  commit_pc,
    input  logic [LANES*ILEN-1:0]  commit_inst,
    input  logic [LANES-1:0]       commit_exit,
    input  logic [XLEN-1:0]        a0,
    output logic                   halted,
    output logic [1:0]             exit_cause,
    output logic [XLEN-1:0]        exit_pc,
    output logic [63:0]            cycle_cnt,
    output logic [63:0]            instret_cnt,
    output logic                   dump_valid,
    output logic [XLEN-1:0]        dump_pc,
    output logic [ILEN-1:0]        dump_inst,
    output logic                   done
);

    localparam int FILL_W = $clog2(HIST_DEPTH + 1);
    localparam int CNT_W  = $clog2(LANES + 1);
    localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e             r_state, w_state_nxt;
    exit_cause_e        r_cause;
    logic [XLEN-1:0]    r_exit_pc, r_last_pc, w_last_pc_nxt;
    logic [63:0]        r_cycle, r_instret;
    logic [WD_W-1:0]    r_wdog;
    logic [FILL_W-1:0]  r_drain_idx, w_fill;
    logic               r_dump_vld;
    logic [XLEN-1:0]    r_dump_pc, w_rd_pc;
    logic [ILEN-1:0]    r_dump_inst, w_rd_inst;
    logic [LANES-1:0]   w_eff;
    logic [CNT_W-1:0]   w_eff_cnt;
    logic               w_exit_hit, w_hang_hit;

    // The exit lane is always the highest effective lane, so w_last_pc_nxt doubles as its pc.
    always_comb begin
        w_eff         = '0;
        w_eff_cnt     = '0;
        w_exit_hit    = 1'b0;
        w_last_pc_nxt = r_last_pc;
        for (int i = 0; i < LANES; i++) begin
            if (r_state == ST_RUN && commit_valid[i] && !w_exit_hit) begin
                w_eff[i]      = 1'b1;
                w_eff_cnt     = w_eff_cnt + CNT_W'(1);
                w_last_pc_nxt = commit_pc[i*XLEN +: XLEN];
                w_exit_hit    = commit_exit[i];
            end
        end
        w_hang_hit = (TIMEOUT != 0) && (r_state == ST_RUN) && (w_eff == '0)
                     && (r_wdog == WD_W'(TIMEOUT - 1));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (w_exit_hit || w_hang_hit) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_drain_idx == w_fill)    w_state_nxt = ST_DONE;
            default:  w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cause     <= CAUSE_NONE;
            r_exit_pc   <= '0;
            r_last_pc   <= '0;
            r_cycle     <= '0;
            r_instret   <= '0;
            r_wdog      <= '0;
            r_drain_idx <= '0;
            r_dump_vld  <= 1'b0;
            r_dump_pc   <= '0;
            r_dump_inst <= '0;
        end else begin
            r_dump_vld <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    r_cycle   <= r_cycle + 64'd1;
                    r_instret <= r_instret + 64'(w_eff_cnt);
                    r_last_pc <= w_last_pc_nxt;
                    r_wdog    <= (w_eff != '0) ? '0 : r_wdog + WD_W'(1);
                    if (w_exit_hit) begin
                        r_cause   <= (a0 == '0) ? CAUSE_GOOD : CAUSE_BAD;
                        r_exit_pc <= w_last_pc_nxt;
                    end else if (w_hang_hit) begin
                        r_cause   <= CAUSE_HANG;
                        r_exit_pc <= r_last_pc;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_idx != w_fill) begin
                        r_dump_vld  <= 1'b1;
                        r_dump_pc   <= w_rd_pc;
                        r_dump_inst <= w_rd_inst;
                        r_drain_idx <= r_drain_idx + FILL_W'(1);
                    end
                end
                default: r_dump_vld <= 1'b0;
            endcase
        end
    end

    trap_hist_ring #(
        .HIST_DEPTH (HIST_DEPTH),
        .XLEN       (XLEN),
        .ILEN       (ILEN),
        .LANES      (LANES)
    ) u_hist (
        .i_clock   (clock),
        .i_rst_n   (reset),
        .i_wr_vld  (w_eff),
        .i_wr_pc   (commit_pc),
        .i_wr_inst (commit_inst),
        .i_rd_idx  (r_drain_idx),
        .o_rd_pc   (w_rd_pc),
        .o_rd_inst (w_rd_inst),
        .o_fill    (w_fill)
    );

    assign halted      = (r_state != ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign exit_cause  = r_cause;
    assign exit_pc     = r_exit_pc;
    assign cycle_cnt   = r_cycle;
    assign instret_cnt = r_instret;
    assign dump_valid  = r_dump_vld;
    assign dump_pc     = r_dump_pc;
    assign dump_inst   = r_dump_inst;

`ifdef TRAP_MONITOR_DISPLAY_EN
    logic [ILEN-1:0] r_last_inst;
    logic            r_halted_q;
    int              r_dump_k;

    always @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_eff[i]) r_last_inst <= commit_inst[i*ILEN +: ILEN];
        end
        r_halted_q <= halted;
        r_dump_k   <= !halted ? 0 : (dump_valid ? r_dump_k + 1 : r_dump_k);
        if (halted && !r_halted_q) begin
            case (r_cause)
                CAUSE_GOOD: $display("hit good trap pc=%h inst=%h", exit_pc, r_last_inst);
                CAUSE_BAD:  $display("hit bad trap pc=%h inst=%h", exit_pc, r_last_inst);
                default:    $display("hang (no commit for %0d cycles) pc=%h inst=%h",
                                     TIMEOUT, exit_pc, r_last_inst);
            endcase
            $display("cycles=%0d instret=%0d ipc=%f", cycle_cnt, instret_cnt,
                     real'(instret_cnt) / real'(cycle_cnt));
        end
        if (dump_valid) $display("[hist %0d] %h %h", r_dump_k, dump_pc, dump_inst);
        if (done) $finish;
    end
`endif

endmodule

// File: tb/tb_trap_monitor.sv
// Directed bench: instance A (1 lane, depth 8, timeout 16), instance B (2 lanes, depth 4).
module tb_trap_monitor;

    logic clock = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clock = ~clock;

    logic [0:0]   a_valid = '0, a_exit = '0;
    logic [63:0]  a_pc = '0, a_a0 = '0;
    logic [31:0]  a_inst = '0;
    logic         a_halted, a_dv, a_done;
    logic [1:0]   a_cause;
    logic [63:0]  a_epc, a_cyc, a_ret, a_dpc;
    logic [31:0]  a_dinst;

    logic [1:0]   b_valid = '0, b_exit = '0;
    logic [127:0] b_pc = '0;
    logic [63:0]  b_inst = '0, b_a0 = '0;
    logic         b_halted, b_dv, b_done;
    logic [1:0]   b_cause;
    logic [63:0]  b_epc, b_cyc, b_ret, b_dpc;
    logic [31:0]  b_dinst;

    trap_monitor #(.XLEN(64), .ILEN(32), .LANES(1), .HIST_DEPTH(8), .TIMEOUT(16)) u_a (
        .clock(clock), .reset(rst_n), .commit_valid(a_valid), .commit_pc(a_pc),
        .commit_inst(a_inst), .commit_exit(a_exit), .a0(a_a0), .halted(a_halted),
        .exit_cause(a_cause), .exit_pc(a_epc), .cycle_cnt(a_cyc), .instret_cnt(a_ret),
        .dump_valid(a_dv), .dump_pc(a_dpc), .dump_inst(a_dinst), .done(a_done));

    trap_monitor #(.XLEN(64), .ILEN(32), .LANES(2), .HIST_DEPTH(4), .TIMEOUT(16)) u_b (
        .clock(clock), .reset(rst_n), .commit_valid(b_valid), .commit_pc(b_pc),
        .commit_inst(b_inst), .commit_exit(b_exit), .a0(b_a0), .halted(b_halted),
        .exit_cause(b_cause), .exit_pc(b_epc), .cycle_cnt(b_cyc), .instret_cnt(b_ret),
        .dump_valid(b_dv), .dump_pc(b_dpc), .dump_inst(b_dinst), .done(b_done));

    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'hA5A5_0000;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        a_valid = '0; a_exit = '0; b_valid = '0; b_exit = '0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_halted", 64'(a_halted), 64'd0);
        chk("rst_cause",  64'(a_cause),  64'd0);
        chk("rst_epc",    a_epc,         64'd0);
        chk("rst_cyc",    a_cyc,         64'd0);
        chk("rst_ret",    a_ret,         64'd0);
        chk("rst_dv",     64'(a_dv),     64'd0);
        chk("rst_done",   64'(a_done),   64'd0);
        chk("rst_b_halted", 64'(b_halted), 64'd0);
        rst_n = 1'b1;
    endtask

    task automatic a_drive(input logic v, input logic [63:0] pc, input logic ex,
                           input logic [63:0] a0v);
        a_valid = v; a_pc = pc; a_inst = inst_of(pc); a_exit = ex; a_a0 = a0v;
        tick();
    endtask

    task automatic a_drain(input string tag, input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_dv"},    64'(a_dv),    64'd1);
            chk({tag, "_dpc"},   a_dpc,        base + 64'(4 * i));
            chk({tag, "_dinst"}, 64'(a_dinst), 64'(inst_of(base + 64'(4 * i))));
        end
        tick();
        chk({tag, "_end_dv"}, 64'(a_dv),   64'd0);
        chk({tag, "_done"},   64'(a_done), 64'd1);
    endtask

    task automatic a_basic(input string tag, input logic [63:0] a0v, input logic [1:0] cause);
        do_reset();
        for (int k = 0; k < 5; k++)
            a_drive(1'b1, 64'h8000_0000 + 64'(4 * k), k == 4, (k == 4) ? a0v : 64'hDEAD);
        // junk commit held during drain must be ignored
        a_valid = 1'b1; a_pc = 64'hBAD0; a_inst = 32'hFFFF_FFFF; a_exit = 1'b1; a_a0 = '0;
        chk({tag, "_halted"}, 64'(a_halted), 64'd1);
        chk({tag, "_cause"},  64'(a_cause),  64'(cause));
        chk({tag, "_epc"},    a_epc,         64'h8000_0010);
        chk({tag, "_ret"},    a_ret,         64'd5);
        chk({tag, "_cyc"},    a_cyc,         64'd5);
        chk({tag, "_dv0"},    64'(a_dv),     64'd0);
        a_drain(tag, 64'h8000_0000, 5);
        chk({tag, "_ret_frz"}, a_ret, 64'd5);
        chk({tag, "_cyc_frz"}, a_cyc, 64'd5);
        a_valid = '0; a_exit = '0;
    endtask

    initial begin
        a_basic("good", 64'd0, 2'd1);
        a_basic("bad",  64'd1, 2'd2);

        // two lanes, depth 4: 10 commits then exit on lane 0 with lane 1 valid
        do_reset();
        for (int c = 0; c < 5; c++) begin
            b_valid = 2'b11; b_exit = 2'b00;
            b_pc    = {64'h1000 + 64'(8 * c + 4), 64'h1000 + 64'(8 * c)};
            b_inst  = {inst_of(64'h1000 + 64'(8 * c + 4)), inst_of(64'h1000 + 64'(8 * c))};
            tick();
        end
        b_valid = 2'b11; b_exit = 2'b01; b_a0 = '0;
        b_pc    = {64'h102C, 64'h1028};
        b_inst  = {inst_of(64'h102C), inst_of(64'h1028)};
        tick();
        b_valid = '0; b_exit = '0;
        chk("wrap_halted", 64'(b_halted), 64'd1);
        chk("wrap_cause",  64'(b_cause),  64'd1);
        chk("wrap_epc",    b_epc,         64'h1028);
        chk("wrap_ret",    b_ret,         64'd11);
        chk("wrap_cyc",    b_cyc,         64'd6);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wrap_dv",    64'(b_dv),    64'd1);
            chk("wrap_dpc",   b_dpc,        64'h101C + 64'(4 * i));
            chk("wrap_dinst", 64'(b_dinst), 64'(inst_of(64'h101C + 64'(4 * i))));
        end
        tick();
        chk("wrap_end_dv", 64'(b_dv),   64'd0);
        chk("wrap_done",   64'(b_done), 64'd1);

        // hang: 3 commits then silence
        do_reset();
        for (int k = 0; k < 3; k++) a_drive(1'b1, 64'h2000 + 64'(4 * k), 1'b0, 64'd0);
        a_valid = '0;
        for (int k = 0; k < 15; k++) tick();
        chk("hang_early", 64'(a_halted), 64'd0);
        tick();
        chk("hang_halted", 64'(a_halted), 64'd1);
        chk("hang_cause",  64'(a_cause),  64'd3);
        chk("hang_epc",    a_epc,         64'h2008);
        chk("hang_ret",    a_ret,         64'd3);
        chk("hang_cyc",    a_cyc,         64'd19);
        a_drain("hang", 64'h2000, 3);

        // exit in the cycle the watchdog would expire
        do_reset();
        a_drive(1'b1, 64'h3000, 1'b0, 64'd0);
        a_valid = '0;
        for (int k = 0; k < 15; k++) tick();
        chk("race_early", 64'(a_halted), 64'd0);
        a_drive(1'b1, 64'h3004, 1'b1, 64'd0);
        a_valid = '0; a_exit = '0;
        chk("race_halted", 64'(a_halted), 64'd1);
        chk("race_cause",  64'(a_cause),  64'd1);
        chk("race_epc",    a_epc,         64'h3004);
        chk("race_ret",    a_ret,         64'd2);
        chk("race_cyc",    a_cyc,         64'd17);
        tick();
        chk("race_dpc0", a_dpc, 64'h3000);
        tick();
        chk("race_dv1",  64'(a_dv), 64'd1);
        chk("race_dpc1", a_dpc,     64'h3004);

        // asynchronous reset in the middle of the drain
        rst_n = 1'b0;
        #1;
        chk("arst_halted", 64'(a_halted), 64'd0);
        chk("arst_cause",  64'(a_cause),  64'd0);
        chk("arst_epc",    a_epc,         64'd0);
        chk("arst_cyc",    a_cyc,         64'd0);
        chk("arst_ret",    a_ret,         64'd0);
        chk("arst_dv",     64'(a_dv),     64'd0);
        chk("arst_dpc",    a_dpc,         64'd0);
        chk("arst_dinst",  64'(a_dinst),  64'd0);
        chk("arst_done",   64'(a_done),   64'd0);
        tick();
        rst_n = 1'b1;
        a_drive(1'b1, 64'h4000, 1'b0, 64'd0);
        a_drive(1'b1, 64'h4004, 1'b1, 64'd5);
        a_valid = '0; a_exit = '0;
        chk("rerun_halted", 64'(a_halted), 64'd1);
        chk("rerun_cause",  64'(a_cause),  64'd2);
        chk("rerun_epc",    a_epc,         64'h4004);
        chk("rerun_ret",    a_ret,         64'd2);
        chk("rerun_cyc",    a_cyc,         64'd2);
        a_drain("rerun", 64'h4000, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
